// File: rtl/ldpc_3gpp_enc_mm_ctrl_pkg.sv
// Shared encoder matrix-multiplier types: lifting size, data word, read strobes
// and the Hb entry descriptor used by both the controller and the mm datapath.
package ldpc_3gpp_enc_mm_ctrl_pkg;

  localparam int cZC_W     = 9;
  localparam int cDAT_W    = 8;
  localparam int cWSHIFT_W = 8;
  localparam int cBSHIFT_W = 3;

  typedef logic [cZC_W-1:0]  hb_zc_t;
  typedef logic [cDAT_W-1:0] dat_t;

  // Packed so that sop is bit 0 and eof is bit 3.
  typedef struct packed {
    logic eof;
    logic sof;
    logic eop;
    logic sop;
  } strb_t;

  typedef struct packed {
    logic [cWSHIFT_W-1:0] wshift;
    logic [cBSHIFT_W-1:0] bshift;
    logic                 is_max;
    logic                 is_masked;
  } mm_hb_value_t;

endpackage

// File: rtl/ldpc_3gpp_enc_mm_ctrl_cnt.sv
// Word counter with synchronous clear, terminal flag at ilast and wrap to zero
// when incremented on the terminal value.
module ldpc_3gpp_enc_mm_ctrl_cnt
  import ldpc_3gpp_enc_mm_ctrl_pkg::*;
#(
  parameter int pW = 9
) (
  input  logic          iclk,
  input  logic          ireset,
  input  logic          iclkena,
  input  logic          iclr,
  input  logic          iinc,
  input  logic [pW-1:0] ilast,
  output logic [pW-1:0] ocnt,
  output logic          otc
);

  localparam logic [pW-1:0] ONE = pW'(1);

  assign otc = (ocnt == ilast);

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      ocnt <= '0;
    end else if (iclkena) begin
      if (iclr || (iinc && otc)) ocnt <= '0;
      else if (iinc)             ocnt <= ocnt + ONE;
    end
  end

endmodule

// File: rtl/ldpc_3gpp_enc_mm_ctrl.sv
// Single-port-RAM matrix-multiplier sequencer: load one Zc block, replay it per Hb entry.
// Optional macro LDPC_3GPP_ENC_MM_CTRL_PREFETCH_EN removes the FETCH gap between columns.
module ldpc_3gpp_enc_mm_ctrl
  import ldpc_3gpp_enc_mm_ctrl_pkg::*;
#(
  parameter int pADDR_W = 8,
  parameter int pCOL_W  = 5,
  parameter int pDAT_W  = 8
) (
  input  logic               iclk,
  input  logic               ireset,
  input  logic               iclkena,
  input  logic               istart,
  input  hb_zc_t             iused_zc,
  input  logic [pADDR_W:0]   inwords,
  input  logic [pCOL_W:0]    incol,
  input  logic               isval,
  input  logic [pDAT_W-1:0]  iwdat,
  output logic               osrdy,
  output logic [pCOL_W-1:0]  ohb_raddr,
  input  mm_hb_value_t       ihb_rdat,
  output hb_zc_t             oused_zc,
  output logic               owrite,
  output logic               owstart,
  output logic [pDAT_W-1:0]  owdat,
  output logic               oread,
  output logic               orstart,
  output mm_hb_value_t       orHb,
  output logic               orval,
  output strb_t              orstrb,
  output logic               obusy,
  output logic               odone
);

  typedef enum logic [2:0] {IDLE, WRITE, FETCH, READ, DONE} state_t;

  localparam logic [pADDR_W:0] ONE = (pADDR_W+1)'(1);
  localparam logic [pADDR_W:0] TWO = (pADDR_W+1)'(2);

  state_t             state;
  logic               fetch_ph;
  logic [pADDR_W:0]   nwords, col, col_inc, col_last, wlast, rlast, wcnt, rcnt;
  logic [pCOL_W:0]    ncol;
  logic               accept, wtc, rtc, last_col;

  assign accept   = (state == WRITE) & isval & iclkena;
  assign wlast    = nwords - ONE;
  assign rlast    = nwords + ONE;
  assign col_inc  = col + ONE;
  assign col_last = (pADDR_W+1)'(ncol) - ONE;
  assign last_col = (col == col_last);

  ldpc_3gpp_enc_mm_ctrl_cnt #(.pW(pADDR_W+1)) u_wcnt (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena),
    .iclr(state == IDLE), .iinc(accept), .ilast(wlast),
    .ocnt(wcnt), .otc(wtc)
  );

  ldpc_3gpp_enc_mm_ctrl_cnt #(.pW(pADDR_W+1)) u_rcnt (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena),
    .iclr(state != READ), .iinc(state == READ), .ilast(rlast),
    .ocnt(rcnt), .otc(rtc)
  );

  // Write port passes data straight through; everything else decodes from registers.
  assign osrdy   = (state == WRITE);
  assign owrite  = accept;
  assign owstart = accept & (wcnt == '0);
  assign owdat   = accept ? iwdat : '0;
  assign oread   = (state == READ);
  assign orstart = oread & (rcnt == '0);
  assign orval   = oread & (rcnt >= TWO);
  assign odone   = (state == DONE);

  always_comb begin
    orstrb     = '0;
    orstrb.sop = orval & (rcnt == TWO);
    orstrb.eop = orval & rtc;
    orstrb.sof = orval & (col == '0);
    orstrb.eof = orval & last_col;
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state     <= IDLE;
      fetch_ph  <= 1'b0;
      obusy     <= 1'b0;
      oused_zc  <= '0;
      nwords    <= '0;
      ncol      <= '0;
      col       <= '0;
      ohb_raddr <= '0;
      orHb      <= '0;
    end else if (iclkena) begin
      case (state)
        IDLE: begin
          if (istart) begin
            oused_zc <= iused_zc;
            nwords   <= inwords;
            ncol     <= incol;
            col      <= '0;
            obusy    <= 1'b1;
            state    <= WRITE;
          end
        end
        WRITE: begin
          if (accept && wtc) begin
            fetch_ph  <= 1'b0;
            ohb_raddr <= '0;
            state     <= (ncol == '0) ? DONE : FETCH;
          end
        end
        FETCH: begin
          // Phase 0 presents the address, phase 1 sees the ROM data.
          fetch_ph <= 1'b1;
          if (fetch_ph) begin
            orHb  <= ihb_rdat;
            state <= READ;
          end
        end
        READ: begin
`ifdef LDPC_3GPP_ENC_MM_CTRL_PREFETCH_EN
          if ((rcnt == wlast) && !last_col) ohb_raddr <= pCOL_W'(col_inc);
`endif
          if (rtc) begin
            col <= col_inc;
            if (last_col) begin
              state <= DONE;
            end else begin
`ifdef LDPC_3GPP_ENC_MM_CTRL_PREFETCH_EN
              orHb <= ihb_rdat;
`else
              ohb_raddr <= pCOL_W'(col_inc);
              fetch_ph  <= 1'b0;
              state     <= FETCH;
`endif
            end
          end
        end
        DONE: begin
          obusy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ldpc_3gpp_enc_mm_ctrl.md
Name: ldpc_3gpp_enc_mm_ctrl

Overview:
Sequencer for the encoder's single-port-RAM matrix multiplier. It loads one Zc-bit block, then replays it once per non-zero Hb entry of the current row as circularly shifted words. It generates all mm write/read controls and fetches Hb entries from the Hb ROM. It sits between the encoder top FSM (start/done) and one matrix-multiplier instance.

Parameters:
pADDR_W, 8, mm RAM address width; max words per block = 2**pADDR_W
pCOL_W, 5, Hb column-list index width
pDAT_W, 8, data word width (dat_t)

Ports:
iclk  in  1  clock
ireset  in  1  asynchronous active-high reset
iclkena  in  1  clock enable; all state frozen when low
istart  in  1  start pulse, sampled only in IDLE
iused_zc  in  hb_zc_t  lifting size Zc, captured at istart
inwords  in  pADDR_W+1  words per block (Zc/pDAT_W, >=2), captured at istart
incol  in  pCOL_W+1  number of Hb entries to replay, captured at istart
isval  in  1  write data valid
iwdat  in  pDAT_W  write data
osrdy  out  1  ready for write data
ohb_raddr  out  pCOL_W  Hb ROM address
ihb_rdat  in  mm_hb_value_t  Hb ROM data, valid 1 cycle after ohb_raddr
oused_zc  out  hb_zc_t  captured Zc to mm
owrite, owstart  out  1  mm write, first-word strobe
owdat  out  pDAT_W  mm write data
oread, orstart  out  1  mm read, read-cycle start
orHb  out  mm_hb_value_t  Hb entry, stable for a whole read cycle
orval  out  1  mm read-data valid
orstrb  out  strb_t  {eof, sof, eop, sop}
obusy  out  1  high from accepted istart to odone
odone  out  1  one-cycle pulse at end of last read cycle

Behaviour:
- Reset: state IDLE. All outputs 0, including osrdy, obusy, odone, owrite, oread, orval and orstrb. Registered captures are cleared.
- Reset is asynchronous, so it aborts any phase mid-operation. No partial odone is produced.
- FSM states: IDLE, WRITE, FETCH, READ, DONE.
- IDLE -> WRITE on istart. Capture Zc, nwords and ncol; clear word and column counters; set obusy.
- WRITE: osrdy=1. Each isval&osrdy cycle drives owrite=1 and owdat=iwdat combinationally. owstart=1 on the first accepted word only. Gaps with isval=0 are allowed.
- WRITE exit: after the nwords-th accepted word, osrdy drops the same cycle and the FSM goes to FETCH. If ncol==0 it goes to DONE instead.
- FETCH: drive ohb_raddr=col, which also lets mm register iused_zc. Next cycle, register ihb_rdat into orHb and go to READ.
- READ: lasts nwords+2 cycles, counter r = 0..nwords+1. oread=1 on every cycle. orstart=1 at r=0. orval=1 for r = 2..nwords+1, so the mm upload pipeline gets exactly nwords valids.
- READ strobes: sop at r=2, eop at r=nwords+1. sof on all valids of column 0; eof on all valids of column ncol-1.
- READ exit at r=nwords+1: increment col. If col==ncol-1 go to DONE, else go to FETCH.
- DONE: odone=1 for one cycle, obusy=0 from the next cycle, return to IDLE.
- owrite and oread are never both high. istart outside IDLE is ignored.
- Widths: all counters are pADDR_W+1 wide. The inwords > 2**pADDR_W condition is not checked; it is the caller's responsibility.

Optional Feature:
LDPC_3GPP_ENC_MM_CTRL_PREFETCH_EN
- Defined: ohb_raddr=col+1 is issued at r=nwords of READ, and orHb is loaded at r=nwords+1 to take effect from the next cycle. READ then goes directly to the next READ with no FETCH gap. Per-column period is nwords+2.
- Undefined: FETCH is inserted between every pair of columns. Per-column period is nwords+4 (FETCH plus ROM latency).

Decomposition:
- hb_zc_t, dat_t, strb_t (4-bit, field order sop/eop/sof/eof) and mm_hb_value_t (wshift, bshift, is_max, is_masked) live in the shared enc types include, shared with mm.
- The state enum stays local.
- One natural sub-module: ldpc_3gpp_enc_mm_ctrl_cnt, a loadable word counter with terminal flag, instantiated for both write and read counting.

Test Plan:
1. Zc=32, pDAT_W=8, nwords=4, ncol=1, isval continuous -> owrite 4 cycles, owstart on first only. oread 6 cycles, orval 4 cycles, sop/eop on cycles 3/6, sof=eof=1 on all valids. odone 1 cycle later.
2. ncol=3, Hb wshift {0,1,3} -> orHb changes only at read-cycle boundaries. Column periods are 8 cycles without the macro and 6 with it. sof on column 0, eof on column 2.
3. isval pattern 1,0,0,1,1,0,1 -> exactly 4 owrite pulses, no owrite while isval=0. osrdy low after the 4th accepted word.
4. ncol=0 -> write phase only, then odone. oread stays 0 throughout.
5. ireset mid-READ at r=2 -> all outputs 0 immediately, no odone. A new istart runs a full clean sequence.
6. istart pulsed while busy; iclkena toggled 0/1 during READ -> no restart. Outputs hold during iclkena=0, and the total cycle count equals the iclkena=1 cycle count.
